// File: rtl/dff_bank_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dff_bank_arbiter_if : requester bus of the shared-register arbiter  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface dff_bank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       we;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [IDW-1:0]        gnt_id;
    logic                  busy;
    logic                  timeout;
    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0]      qbar;

    modport slave (
        input  req, we, wdata,
        output gnt, gnt_id, busy, timeout, q, qbar
    );

    modport master (
        output req, we, wdata,
        input  gnt, gnt_id, busy, timeout, q, qbar
    );
endinterface
`default_nettype wire

// File: rtl/dff_bank_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dff_bank_arbiter : round-robin owner arbitration and write control  |
// | for one shared WIDTH-bit register with q/qbar outputs.              |
// | Option macro DFF_ARB_FIXED_PRIO_EN selects fixed priority.          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module dff_bank_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dff_bank_arbiter_if.slave      arb_bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW  = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWNED   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             timeout_q, timeout_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic             w_win_vld;
    logic [IDW-1:0]   w_win_idx;
    logic [IDW-1:0]   w_rot_ptr;

    // First asserted request at or after ptr, wrapping around.
    always_comb begin : arbitration
        int scan;
        scan      = 0;
        w_win_vld = 1'b0;
        w_win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan = int'(ptr_q) + i;
            if (scan >= NREQ) begin
                scan = scan - NREQ;
            end
            if (!w_win_vld && arb_bus.req[IDW'(scan)]) begin
                w_win_vld = 1'b1;
                w_win_idx = IDW'(scan);
            end
        end
    end

`ifdef DFF_ARB_FIXED_PRIO_EN
    assign w_rot_ptr = '0;
`else
    assign w_rot_ptr = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
`endif

    always_comb begin : next_state
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        timeout_d = 1'b0;
        data_d    = data_q;
        unique case (state_q)
            IDLE: begin
                if (w_win_vld) begin
                    state_d = OWNED;
                    owner_d = w_win_idx;
                    gnt_d   = NREQ'(1) << w_win_idx;
                    hold_d  = '0;
                end
            end
            OWNED: begin
                if (!arb_bus.req[owner_q]) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    owner_d = '0;
                    hold_d  = '0;
                    ptr_d   = w_rot_ptr;
                end else begin
                    if (arb_bus.we[owner_q]) begin
                        data_d = arb_bus.wdata[int'(owner_q)*WIDTH +: WIDTH];
                    end
                    hold_d = hold_q + 1'b1;
                    // Last permitted cycle: the write above still lands.
                    if (hold_q == HW'(MAX_HOLD - 1)) begin
                        state_d   = RELEASE;
                        gnt_d     = '0;
                        owner_d   = '0;
                        hold_d    = '0;
                        timeout_d = 1'b1;
                        ptr_d     = w_rot_ptr;
                    end
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            timeout_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            timeout_q <= timeout_d;
            data_q    <= data_d;
        end
    end

    assign arb_bus.gnt     = gnt_q;
    assign arb_bus.gnt_id  = owner_q;
    assign arb_bus.busy    = (state_q != IDLE);
    assign arb_bus.timeout = timeout_q;
    assign arb_bus.q       = data_q;
    assign arb_bus.qbar    = ~data_q;
endmodule
`default_nettype wire

// File: tb/tb_dff_bank_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dff_bank_arbiter : scoreboard bench for dff_bank_arbiter         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_dff_bank_arbiter;
    localparam int NREQ     = 4;
    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dff_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .arb_bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns, how long it has held, and whose turn is next.
    typedef struct packed {
        logic [NREQ-1:0]  gnt;
        logic [1:0]       id;
        logic             busy;
        logic             to;
        logic [WIDTH-1:0] q;
    } exp_t;

    exp_t sb[$];
    int   m_owner = -1;
    int   m_held  = 0;
    int   m_next  = 0;
    bit   m_rel   = 1'b0;
    bit   m_to    = 1'b0;
    logic [WIDTH-1:0] m_q = '0;

    function automatic exp_t m_out();
        exp_t e;
        e.gnt  = (m_owner < 0) ? '0 : NREQ'(1) << m_owner;
        e.id   = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        e.busy = (m_owner >= 0) || m_rel;
        e.to   = m_to;
        e.q    = m_q;
        return e;
    endfunction

    function automatic void m_release();
`ifdef DFF_ARB_FIXED_PRIO_EN
        m_next = 0;
`else
        m_next = (m_owner + 1) % NREQ;
`endif
        m_owner = -1;
        m_rel   = 1'b1;
    endfunction

    function automatic void m_step();
        int c;
        m_to = 1'b0;
        if (m_rel) begin
            m_rel = 1'b0;
        end else if (m_owner < 0) begin
            for (int i = 0; i < NREQ; i++) begin
                c = (m_next + i) % NREQ;
                if (m_owner < 0 && bus.req[c] === 1'b1) begin
                    m_owner = c;
                    m_held  = 0;
                end
            end
        end else if (bus.req[m_owner] !== 1'b1) begin
            m_release();
        end else begin
            if (bus.we[m_owner] === 1'b1) m_q = bus.wdata[m_owner*WIDTH +: WIDTH];
            m_held++;
            if (m_held == MAX_HOLD) begin
                m_to = 1'b1;
                m_release();
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_held  = 0;
            m_next  = 0;
            m_rel   = 1'b0;
            m_to    = 1'b0;
            m_q     = '0;
            sb.delete();
        end else begin
            m_step();
        end
        sb.push_back(m_out());
    end

    always @(negedge clk) begin
        exp_t e;
        logic [WIDTH-1:0] qb;
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            qb = ~e.q;
            chk("sb_gnt", bus.gnt, e.gnt);
            chk("sb_gnt_id", bus.gnt_id, e.id);
            chk("sb_busy", bus.busy, e.busy);
            chk("sb_timeout", bus.timeout, e.to);
            chk("sb_q", bus.q, e.q);
            chk("sb_qbar", bus.qbar, qb);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_gnt(output int id);
        int n;
        n  = 0;
        id = -1;
        while (bus.gnt == '0 && n < 20) begin
            cyc(1);
            n++;
        end
        checks++;
        if (bus.gnt == '0) begin
            errors++;
            $display("FAIL wait_gnt actual=no_grant expected=grant_within_20 time=%0t", $time);
        end else begin
            id = int'(bus.gnt_id);
        end
    endtask

    task automatic async_reset_mid();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_gnt", bus.gnt, 4'b0000);
        chk("async_busy", bus.busy, 1'b0);
        chk("async_q", bus.q, 8'h00);
        chk("async_qbar", bus.qbar, 8'hFF);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int id;
        int exp_order[5];
        logic [WIDTH-1:0] q_before;
        logic [NREQ-1:0]  tog;

        bus.req   = '0;
        bus.we    = '0;
        bus.wdata = '0;

        // Reset held with random traffic, then idle
        #1 rst_n = 1'b0;
        repeat (3) begin
            bus.req = 4'($urandom);
            bus.we  = 4'($urandom);
            cyc(1);
        end
        rst_n   = 1'b1;
        bus.req = '0;
        bus.we  = '0;
        cyc(3);

        // Single write by requester 2
        bus.wdata[2*WIDTH +: WIDTH] = 8'hA5;
        bus.req = 4'b0100;
        bus.we  = 4'b0100;
        wait_gnt(id);
        chk("single_gnt", bus.gnt, 4'b0100);
        chk("single_gnt_id", bus.gnt_id, 2);
        cyc(1);
        chk("single_q", bus.q, 8'hA5);
        chk("single_qbar", bus.qbar, 8'h5A);
        bus.req = '0;
        bus.we  = '0;
        cyc(1);
        chk("release_busy", bus.busy, 1'b1);
        chk("release_gnt", bus.gnt, 4'b0000);
        cyc(1);
        chk("idle_busy", bus.busy, 1'b0);

        // Fairness from reset
        async_reset_mid();
`ifdef DFF_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        bus.req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            wait_gnt(id);
            chk("grant_order", id, exp_order[r]);
            if (id >= 0) begin
                cyc(1);
                bus.req[id] = 1'b0;
                cyc(1);
                bus.req[id] = 1'b1;
            end
        end
        bus.req = '0;
        cyc(4);

        // Forced revoke with a competing requester
        bus.req = 4'b0110;
        repeat (12) begin
            bus.we = 4'($urandom);
            bus.wdata = 32'($urandom);
            cyc(1);
        end
        bus.req = '0;
        bus.we  = '0;
        cyc(4);

        // Foreign write attempt while requester 0 owns
        q_before = m_q;
        bus.wdata[3*WIDTH +: WIDTH] = 8'hFF;
        bus.req = 4'b0001;
        bus.we  = 4'b1000;
        cyc(5);
        chk("foreign_q", bus.q, q_before);
        bus.req = '0;
        bus.we  = '0;
        cyc(3);

        // Async reset while requester 1 owns with 3C stored
        bus.wdata[1*WIDTH +: WIDTH] = 8'h3C;
        bus.req = 4'b0010;
        bus.we  = 4'b0010;
        wait_gnt(id);
        cyc(1);
        chk("mid_q", bus.q, 8'h3C);
        async_reset_mid();
        bus.req = '0;
        bus.we  = '0;
        cyc(2);

        // Random traffic with occasional async resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset_mid();
            end else begin
                tog       = 4'($urandom) & 4'($urandom);
                bus.req   = bus.req ^ tog;
                bus.we    = 4'($urandom);
                bus.wdata = 32'($urandom);
                cyc(1);
            end
        end

        bus.req = '0;
        bus.we  = '0;
        cyc(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
